// File: rtl/cdc_handshake_tx_if.sv
// Bundle of source-side handshake signals for the CDC launch block.
// The slave modport is the launch block. The master modport is whatever feeds it
// words and carries the returning ack toggle.
interface cdc_handshake_tx_if #(
  parameter int N = 8
);
  logic         src_valid;
  logic [N-1:0] src_data;
  logic         src_ready;
  logic         ack_tgl_in;
  logic         err_clr;
  logic [N-1:0] tx_data;
  logic         tx_req_tgl;
  logic         done;
  logic         busy;
  logic         timeout_err;
  logic         protocol_err;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready,
    output ack_tgl_in,
    output err_clr,
    input  tx_data,
    input  tx_req_tgl,
    input  done,
    input  busy,
    input  timeout_err,
    input  protocol_err
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready,
    input  ack_tgl_in,
    input  err_clr,
    output tx_data,
    output tx_req_tgl,
    output done,
    output busy,
    output timeout_err,
    output protocol_err
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Launch half of a toggle req/ack clock-domain-crossing handshake.
// The block captures one word and holds it on tx_data. It flips tx_req_tgl to
// announce the word. It waits until the synchronized ack toggle matches
// tx_req_tgl, and only then accepts the next word.
module cdc_handshake_tx #(
  parameter int N              = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 i_clk_in,
  input  logic                 i_rst_in,
  cdc_handshake_tx_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_ack_sync;
  logic                     w_ack_sync;
  logic [N-1:0]             r_tx_data;
  logic [N-1:0]             w_tx_data_nxt;
  logic                     r_tgl;
  logic                     w_tgl_nxt;
  logic                     r_done;
  logic                     w_done_nxt;
  logic [15:0]              r_cnt;
  logic [15:0]              w_cnt_nxt;
  logic [15:0]              w_cnt_inc;
  logic                     r_terr;
  logic                     w_terr_nxt;
  logic                     r_perr;
  logic                     w_perr_nxt;
  logic                     w_set_terr;
  logic                     w_set_perr;

  // The last flop of the chain is the only ack value the FSM may look at.
  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];

  // The wait counter saturates, so a very long stall never wraps back to zero.
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

  // Ack toggle synchronizer: a plain shift chain clocked in the source domain.
  always_ff @(posedge i_clk_in) begin
    if (i_rst_in) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_tgl_in};
    end
  end

  // Next state and next register values for the handshake FSM and its error flags.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_data_nxt = r_tx_data;
    w_tgl_nxt     = r_tgl;
    w_done_nxt    = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_set_terr    = 1'b0;
    w_set_perr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An ack edge arriving while nothing is outstanding is spurious or a duplicate.
        if (w_ack_sync != r_tgl) begin
          w_set_perr = 1'b1;
        end else begin
          w_set_perr = 1'b0;
        end
        if (bus.src_valid) begin
          w_tx_data_nxt = bus.src_data;
          w_tgl_nxt     = ~r_tgl;
          w_cnt_nxt     = 16'd0;
          w_state_nxt   = ST_WAIT_ACK;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        w_cnt_nxt = w_cnt_inc;
        // The flag fires once, on the cycle the count first lands on the limit.
        if (TIMEOUT_EN && (w_cnt_inc == TIMEOUT_LIM) && (r_cnt != TIMEOUT_LIM)) begin
          w_set_terr = 1'b1;
        end else begin
          w_set_terr = 1'b0;
        end
        if (w_ack_sync == r_tgl) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The flags are sticky. A set condition in the same cycle as err_clr wins.
    if (w_set_terr) begin
      w_terr_nxt = 1'b1;
    end else if (bus.err_clr) begin
      w_terr_nxt = 1'b0;
    end else begin
      w_terr_nxt = r_terr;
    end
    if (w_set_perr) begin
      w_perr_nxt = 1'b1;
    end else if (bus.err_clr) begin
      w_perr_nxt = 1'b0;
    end else begin
      w_perr_nxt = r_perr;
    end
  end

  // State and output registers. Reset drops any in-flight word.
  always_ff @(posedge i_clk_in) begin
    if (i_rst_in) begin
      r_state   <= ST_IDLE;
      r_tx_data <= '0;
      r_tgl     <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= 16'd0;
      r_terr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tgl     <= w_tgl_nxt;
      r_done    <= w_done_nxt;
      r_cnt     <= w_cnt_nxt;
      r_terr    <= w_terr_nxt;
      r_perr    <= w_perr_nxt;
    end
  end

  assign bus.src_ready    = (r_state == ST_IDLE) & ~i_rst_in;
  assign bus.busy         = (r_state == ST_WAIT_ACK);
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_req_tgl   = r_tgl;
  assign bus.done         = r_done;
  assign bus.timeout_err  = r_terr;
  assign bus.protocol_err = r_perr;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx.
// A transaction-level reference model is checked against the DUT on every
// falling edge. Literal checks pin the key cycles of each scenario.
module tb_cdc_handshake_tx;
  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  cdc_handshake_tx_if #(.N(N)) bus_if ();

  cdc_handshake_tx #(
    .N(N), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .i_clk_in (clk),
    .i_rst_in (rst),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The FSM acts on the ack level that was sampled SYNC edges earlier.
  // The model keeps a delay line of raw samples and reasons about transfers, not flops.
  bit         m_started = 1'b0;
  bit         m_waiting = 1'b0;
  bit         m_tgl = 1'b0;
  bit [N-1:0] m_data = '0;
  bit         m_done = 1'b0;
  int         m_wait_cycles = 0;
  bit         m_terr = 1'b0;
  bit         m_perr = 1'b0;
  bit         ack_hist[$];

  // Model update: one transfer step per rising edge.
  always @(posedge clk) begin
    bit seen, set_t, set_p, done_n;
    int prev;
    m_started = 1'b1;
    if (rst) begin
      m_waiting = 1'b0; m_tgl = 1'b0; m_data = '0; m_done = 1'b0;
      m_wait_cycles = 0; m_terr = 1'b0; m_perr = 1'b0;
      ack_hist = {};
      for (int i = 0; i < SYNC; i++) ack_hist.push_back(1'b0);
    end else begin
      seen = ack_hist[SYNC-1];
      ack_hist.push_front(bus_if.ack_tgl_in);
      void'(ack_hist.pop_back());
      set_t = 1'b0; set_p = 1'b0; done_n = 1'b0;
      if (!m_waiting) begin
        if (seen != m_tgl) set_p = 1'b1;
        if (bus_if.src_valid) begin
          m_data = bus_if.src_data;
          m_tgl = ~m_tgl;
          m_wait_cycles = 0;
          m_waiting = 1'b1;
        end
      end else begin
        prev = m_wait_cycles;
        if (m_wait_cycles < 65535) m_wait_cycles++;
        if (TOUT != 0 && prev < TOUT && m_wait_cycles == TOUT) set_t = 1'b1;
        if (seen == m_tgl) begin
          m_waiting = 1'b0;
          done_n = 1'b1;
        end
      end
      m_terr = set_t | (m_terr & ~bus_if.err_clr);
      m_perr = set_p | (m_perr & ~bus_if.err_clr);
      m_done = done_n;
    end
  end

  // Continuous compare of every output on the falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("src_ready",    32'(bus_if.src_ready),    32'(!m_waiting && !rst));
      check("busy",         32'(bus_if.busy),         32'(m_waiting));
      check("tx_data",      32'(bus_if.tx_data),      32'(m_data));
      check("tx_req_tgl",   32'(bus_if.tx_req_tgl),   32'(m_tgl));
      check("done",         32'(bus_if.done),         32'(m_done));
      check("timeout_err",  32'(bus_if.timeout_err),  32'(m_terr));
      check("protocol_err", 32'(bus_if.protocol_err), 32'(m_perr));
    end
  end

  // Advance n rising edges, then settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus_if.src_valid  = 1'b0;
    bus_if.src_data   = '0;
    bus_if.ack_tgl_in = 1'b0;
    bus_if.err_clr    = 1'b0;

    // 1 Reset
    tick(1);
    #1 check("rst_ready_low", 32'(bus_if.src_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    check("rst_ready_high", 32'(bus_if.src_ready), 32'd1);
    check("rst_tgl", 32'(bus_if.tx_req_tgl), 32'd0);
    check("rst_data", 32'(bus_if.tx_data), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_errs", 32'({bus_if.timeout_err, bus_if.protocol_err}), 32'd0);

    // 2 Single transfer, accepted at edge T
    bus_if.src_valid = 1'b1; bus_if.src_data = 8'hA5;
    tick(1);
    bus_if.src_valid = 1'b0;
    #1;
    check("t2_data", 32'(bus_if.tx_data), 32'hA5);
    check("t2_tgl", 32'(bus_if.tx_req_tgl), 32'd1);
    check("t2_busy", 32'(bus_if.busy), 32'd1);
    tick(3);                       // after T+3
    bus_if.ack_tgl_in = 1'b1;      // before edge T+4
    tick(2);                       // after T+5
    #1 check("t2_done_early", 32'(bus_if.done), 32'd0);
    tick(1);                       // after T+6
    #1;
    check("t2_done", 32'(bus_if.done), 32'd1);
    check("t2_ready", 32'(bus_if.src_ready), 32'd1);
    tick(1);
    #1 check("t2_done_once", 32'(bus_if.done), 32'd0);

    // 3 Back-to-back, accepted at edge A (tgl 1->0), then 8'h02 (tgl 0->1)
    bus_if.src_valid = 1'b1; bus_if.src_data = 8'h01;
    tick(1);                       // after A
    #1 check("t3_tgl_a", 32'(bus_if.tx_req_tgl), 32'd0);
    bus_if.src_data = 8'h02;
    tick(1);                       // after A+1
    bus_if.ack_tgl_in = 1'b0;      // before edge A+2
    #1 check("t3_data_a", 32'(bus_if.tx_data), 32'h01);
    tick(3);                       // after A+4
    #1;
    check("t3_ready_back", 32'(bus_if.src_ready), 32'd1);
    check("t3_data_held", 32'(bus_if.tx_data), 32'h01);
    tick(1);                       // after A+5
    bus_if.src_valid = 1'b0;
    #1;
    check("t3_data_b", 32'(bus_if.tx_data), 32'h02);
    check("t3_tgl_b", 32'(bus_if.tx_req_tgl), 32'd1);
    check("t3_busy_b", 32'(bus_if.busy), 32'd1);
    bus_if.ack_tgl_in = 1'b1;
    tick(4);

    // 4 Hold: valid stays high and data churns while waiting
    bus_if.src_valid = 1'b1; bus_if.src_data = 8'h3C;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      bus_if.src_data = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick(1);
    end
    #1;
    check("t4_data_hold", 32'(bus_if.tx_data), 32'h3C);
    check("t4_tgl_hold", 32'(bus_if.tx_req_tgl), 32'd0);
    bus_if.src_valid = 1'b0;
    bus_if.ack_tgl_in = 1'b0;
    tick(4);

    // 5 Timeout after 16 waiting cycles, late ack still completes
    bus_if.src_valid = 1'b1; bus_if.src_data = 8'h5A;
    tick(1);                       // accept at T
    bus_if.src_valid = 1'b0;
    tick(15);                      // after T+15
    #1 check("t5_no_to_yet", 32'(bus_if.timeout_err), 32'd0);
    tick(1);                       // after T+16
    #1 check("t5_timeout", 32'(bus_if.timeout_err), 32'd1);
    tick(4);
    bus_if.ack_tgl_in = 1'b1;
    tick(3);
    #1;
    check("t5_late_done", 32'(bus_if.done), 32'd1);
    check("t5_sticky", 32'(bus_if.timeout_err), 32'd1);
    tick(2);
    bus_if.err_clr = 1'b1;
    tick(1);
    bus_if.err_clr = 1'b0;
    #1 check("t5_cleared", 32'(bus_if.timeout_err), 32'd0);

    // 6 Spurious ack while IDLE, set beats clear, then reset mid-wait
    bus_if.ack_tgl_in = 1'b0;      // tgl is 1, so this is spurious
    tick(3);
    #1;
    check("t6_perr", 32'(bus_if.protocol_err), 32'd1);
    check("t6_no_done", 32'(bus_if.done), 32'd0);
    bus_if.err_clr = 1'b1;         // mismatch persists: set wins
    tick(1);
    bus_if.err_clr = 1'b0;
    #1 check("t6_set_wins", 32'(bus_if.protocol_err), 32'd1);
    bus_if.ack_tgl_in = 1'b1;
    tick(4);
    #1 check("t6_perr_sticky", 32'(bus_if.protocol_err), 32'd1);
    bus_if.src_valid = 1'b1; bus_if.src_data = 8'hC3;
    tick(1);
    bus_if.src_valid = 1'b0;
    tick(2);
    rst = 1'b1;
    bus_if.ack_tgl_in = 1'b0;
    tick(1);
    #1;
    check("t6_rst_ready", 32'(bus_if.src_ready), 32'd0);
    check("t6_rst_tgl", 32'(bus_if.tx_req_tgl), 32'd0);
    check("t6_rst_busy", 32'(bus_if.busy), 32'd0);
    check("t6_rst_perr", 32'(bus_if.protocol_err), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    #1 check("t6_idle_after", 32'(bus_if.src_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
